// File: rtl/memp_sweep_ctrl.sv
// Sweep sequencer and write-port arbiter for an async-read / sync-write vector memory.
// Streams base..base+len-1 to a datapath, writes results back in order, then pulses finish.
module memp_sweep_ctrl #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_addr,
  input  logic [address_width-1:0]             sweep_len,
  input  logic                                 host_we,
  input  logic [address_width-1:0]             host_addr,
  input  logic [no_of_units*element_width-1:0] host_data,
  output logic                                 host_ready,
  output logic [address_width-1:0]             mem_read_address,
  input  logic [no_of_units*element_width-1:0] mem_output,
  output logic                                 mem_write_enable,
  output logic [address_width-1:0]             mem_write_address,
  output logic [no_of_units*element_width-1:0] mem_input_data,
  output logic                                 out_valid,
  output logic [no_of_units*element_width-1:0] out_data,
  input  logic                                 out_ready,
  input  logic                                 wb_valid,
  input  logic [no_of_units*element_width-1:0] wb_data,
  output logic                                 busy,
  output logic                                 finish,
  output logic                                 error
);

  localparam int AW = address_width;
  localparam int CW = address_width + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   wb_cnt_q, wb_cnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   len_q, len_d;
  logic            error_q, error_d;

  logic [CW-1:0]   len_ext;
  logic [CW-1:0]   end_addr;

  assign len_ext  = {1'b0, len_q};
  assign end_addr = {1'b0, base_addr} + {1'b0, sweep_len} - CW'(1);
  assign out_data = mem_output;
  assign error    = error_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    // NOTE: every output and next-state value gets a default here so no path leaves a latch.
    state_d           = state_q;
    rd_cnt_d          = rd_cnt_q;
    wb_cnt_d          = wb_cnt_q;
    base_d            = base_q;
    len_d             = len_q;
    error_d           = error_q;
    host_ready        = 1'b0;
    out_valid         = 1'b0;
    finish            = 1'b0;
    mem_read_address  = base_q + rd_cnt_q[AW-1:0];
    mem_write_enable  = 1'b0;
    mem_write_address = base_q + wb_cnt_q[AW-1:0];
    mem_input_data    = wb_data;

    case (state_q)
      IDLE: begin
        host_ready        = 1'b1;
        mem_write_enable  = host_we;
        mem_write_address = host_addr;
        mem_input_data    = host_data;
        if (start) begin
          base_d   = base_addr;
          len_d    = sweep_len;
          rd_cnt_d = '0;
          wb_cnt_d = '0;
          error_d  = 1'b0;
          if (sweep_len == '0)                    state_d = DONE;
          else if (end_addr > CW'(memory_height)) error_d = 1'b1;
          else                                    state_d = SWEEP;
        end
      end
      SWEEP, DRAIN: begin
        out_valid = (state_q == SWEEP) && (rd_cnt_q < len_ext);
        if (out_valid && out_ready) rd_cnt_d = rd_cnt_q + CW'(1);
        // A result is only legal for a word already handed out, so the write always trails the read.
        if (wb_valid) begin
          if (wb_cnt_q < rd_cnt_q) begin
            mem_write_enable = 1'b1;
            wb_cnt_d         = wb_cnt_q + CW'(1);
          end else begin
            error_d = 1'b1;
          end
        end
        if (wb_cnt_d == len_ext)      state_d = DONE;
        else if (rd_cnt_d == len_ext) state_d = DRAIN;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset aborts immediately: nothing may be committed on the reset edge.
    if (rst) mem_write_enable = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
      wb_cnt_q <= '0;
      base_q   <= '0;
      len_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
      wb_cnt_q <= wb_cnt_d;
      base_q   <= base_d;
      len_q    <= len_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_memp_sweep_ctrl.sv
// Self-checking bench for memp_sweep_ctrl with a behavioural async-read/sync-write memory
// and a datapath model that echoes each streamed word +1 after a configurable delay.
module tb_memp_sweep_ctrl;

  localparam int AW = 11;
  localparam int W  = 256;
  localparam int MH = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr, sweep_len;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [W-1:0]  host_data;
  logic          host_ready;
  logic [AW-1:0] mem_read_address;
  logic [W-1:0]  mem_output;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_address;
  logic [W-1:0]  mem_input_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          wb_valid;
  logic [W-1:0]  wb_data;
  logic          busy, finish, error;

  memp_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .sweep_len(sweep_len),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data), .host_ready(host_ready),
    .mem_read_address(mem_read_address), .mem_output(mem_output),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_input_data(mem_input_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .wb_valid(wb_valid), .wb_data(wb_data),
    .busy(busy), .finish(finish), .error(error)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(int a);
    logic [31:0] w;
    w = 32'(a) ^ 32'hA5A5_0000;
    return {8{w}};
  endfunction

  // Memory model
  logic         mem_init;
  logic [W-1:0] mem [0:MH];
  assign mem_output = (mem_read_address <= AW'(MH)) ? mem[mem_read_address] : '0;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i <= MH; i++) mem[i] <= pat(i);
    end else if (mem_write_enable && mem_write_address <= AW'(MH)) begin
      mem[mem_write_address] <= mem_input_data;
    end
  end

  logic [W-1:0] golden [0:MH];
  int n_pass, n_total;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(negedge clk);
    check("host_ready_idle", W'(host_ready), W'(1));
    check("host_we_pass", W'(mem_write_enable), W'(1));
    step();
    host_we = 1'b0;
    golden[a] = d;
    check("host_wr_mem", mem[a], d);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1; base_addr = b; sweep_len = l;
    step();
    start = 1'b0;
  endtask

  typedef struct { logic [W-1:0] d; int due; } wb_t;

  // Runs an already-started sweep to completion; returns 1 in consec if all handshakes were back-to-back.
  task automatic run_sweep(input int b, input int l, input bit rand_ready, input int delay,
                           output bit consec);
    wb_t q[$];
    int nrd, nwr, bad_rd, bad_wr, bad_mem, last_hs;
    bit fin;
    nrd = 0; nwr = 0; bad_rd = 0; bad_wr = 0; bad_mem = 0; last_hs = -1; fin = 0; consec = 1;
    for (int c = 0; c < 400 && !fin; c++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (q.size() > 0 && q[0].due <= c) begin
        wb_valid = 1'b1; wb_data = q[0].d; void'(q.pop_front());
      end else begin
        wb_valid = 1'b0;
      end
      @(negedge clk);
      if (mem_write_enable) begin
        if (mem_write_address !== AW'(b + nwr)) bad_wr++;
        nwr++;
      end
      if (out_valid && out_ready) begin
        if (out_data !== golden[b + nrd]) bad_rd++;
        q.push_back('{out_data + W'(1), c + delay});
        if (last_hs >= 0 && c != last_hs + 1) consec = 0;
        last_hs = c;
        nrd++;
      end
      if (finish) begin
        fin = 1;
        check("finish_after_writes", W'(nwr), W'(l));
      end
      step();
    end
    wb_valid = 1'b0; out_ready = 1'b0;
    check("sweep_finished", W'(fin), W'(1));
    check("sweep_reads", W'(nrd), W'(l));
    check("sweep_read_data", W'(bad_rd), W'(0));
    check("sweep_write_addr", W'(bad_wr), W'(0));
    @(negedge clk);
    check("busy_drops", W'(busy), W'(0));
    check("finish_single", W'(finish), W'(0));
    for (int i = 0; i < l; i++) begin
      if (mem[b + i] !== golden[b + i] + W'(1)) bad_mem++;
      golden[b + i] = golden[b + i] + W'(1);
    end
    check("sweep_mem_result", W'(bad_mem), W'(0));
    step();
  endtask

  typedef struct {
    logic [AW-1:0] b;
    logic [AW-1:0] l;
    logic          exp_err;
    logic          exp_done;
  } vec_t;

  vec_t tbl [6];
  bit   consec;

  initial begin
    tbl[0] = '{11'd999,  11'd3,    1'b1, 1'b0};
    tbl[1] = '{11'd0,    11'd0,    1'b0, 1'b1};
    tbl[2] = '{11'd1000, 11'd2,    1'b1, 1'b0};
    tbl[3] = '{11'd5,    11'd2047, 1'b1, 1'b0};
    tbl[4] = '{11'd2047, 11'd1,    1'b1, 1'b0};
    tbl[5] = '{11'd1000, 11'd0,    1'b0, 1'b1};

    n_pass = 0; n_total = 0;
    for (int i = 0; i <= MH; i++) golden[i] = pat(i);
    rst = 1'b1; mem_init = 1'b1; start = 1'b0; base_addr = '0; sweep_len = '0;
    host_we = 1'b0; host_addr = '0; host_data = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_data = '0;
    step(); step();
    host_we = 1'b1;
    @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_finish", W'(finish), W'(0));
    check("rst_error", W'(error), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_write_gated", W'(mem_write_enable), W'(0));
    step();
    host_we = 1'b0; rst = 1'b0; mem_init = 1'b0;
    step();

    // Start requests that are rejected or complete immediately
    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].b, tbl[i].l);
      @(negedge clk);
      check("tbl_error", W'(error), W'(tbl[i].exp_err));
      check("tbl_busy", W'(busy), W'(tbl[i].exp_done));
      check("tbl_finish", W'(finish), W'(tbl[i].exp_done));
      check("tbl_no_write", W'(mem_write_enable), W'(0));
      check("tbl_no_read", W'(out_valid), W'(0));
      step();
      if (tbl[i].exp_done) begin
        @(negedge clk);
        check("tbl_back_idle", W'(busy), W'(0));
        check("tbl_finish_once", W'(finish), W'(0));
        step();
      end
    end

    // Basic sweep over host-loaded words
    host_write(11'd5, {8{32'h1111_1111}});
    host_write(11'd6, {8{32'h2222_2222}});
    do_start(11'd5, 11'd2);
    run_sweep(5, 2, 0, 1, consec);
    check("basic_consecutive", W'(consec), W'(1));

    // Backpressure and late writeback
    do_start(11'd100, 11'd16);
    run_sweep(100, 16, 1, 4, consec);

    // Host write and start on the same edge
    host_we = 1'b1; host_addr = 11'd300; host_data = {8{32'hCAFE_F00D}};
    do_start(11'd300, 11'd1);
    host_we = 1'b0;
    golden[300] = {8{32'hCAFE_F00D}};
    check("simul_host_wr", mem[300], golden[300]);
    run_sweep(300, 1, 0, 1, consec);

    // Writeback before any read handshake
    do_start(11'd400, 11'd4);
    out_ready = 1'b0; wb_valid = 1'b1; wb_data = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    check("early_wb_no_write", W'(mem_write_enable), W'(0));
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    check("early_wb_error", W'(error), W'(1));
    check("early_wb_busy", W'(busy), W'(1));
    step();
    run_sweep(400, 4, 0, 2, consec);
    check("error_sticky", W'(error), W'(1));

    // Reset in the middle of a sweep
    do_start(11'd20, 11'd8);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pre_rst_read", out_data, golden[20 + k]);
      step();
    end
    out_ready = 1'b0; rst = 1'b1; wb_valid = 1'b1; wb_data = {8{32'hBAD0_BAD0}};
    @(negedge clk);
    check("rst_mid_no_write", W'(mem_write_enable), W'(0));
    step();
    rst = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", W'(busy), W'(0));
    check("rst_mid_finish", W'(finish), W'(0));
    check("rst_mid_error", W'(error), W'(0));
    check("rst_mid_host_ready", W'(host_ready), W'(1));
    check("rst_mid_mem_kept", mem[20], golden[20]);
    step();
    host_write(11'd21, {8{32'h5A5A_5A5A}});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
